// File: rtl/uart_fifo_bridge.sv
// Host-side TX/RX byte FIFOs between the bus and the UART data register.
// TX drains into the core with a we/wait handshake; RX captures eagerly.
module uart_fifo_bridge #(
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        tx_we,
    input  logic [7:0]                  tx_di,
    output logic                        tx_full,
    output logic [$clog2(TX_DEPTH):0]   tx_count,
    input  logic                        tx_flush,
    input  logic                        rx_re,
    output logic [7:0]                  rx_do,
    output logic                        rx_valid,
    output logic [$clog2(RX_DEPTH):0]   rx_count,
    input  logic                        rx_flush,
    output logic                        rx_overrun,
    input  logic                        clr_overrun,
    output logic                        uart_dat_we,
    output logic [7:0]                  uart_dat_di,
    input  logic                        uart_dat_wait,
    output logic                        uart_dat_re,
    input  logic [31:0]                 uart_dat_do
);

    localparam int TAW = $clog2(TX_DEPTH);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam int TCW = TAW + 1;
    localparam int RCW = RAW + 1;

    logic [7:0]     tx_mem_q [TX_DEPTH];
    logic [TAW-1:0] tx_wptr_q, tx_wptr_d;
    logic [TAW-1:0] tx_rptr_q, tx_rptr_d;
    logic [TCW-1:0] tx_count_q, tx_count_d;

    logic [7:0]     rx_mem_q [RX_DEPTH];
    logic [RAW-1:0] rx_wptr_q, rx_wptr_d;
    logic [RAW-1:0] rx_rptr_q, rx_rptr_d;
    logic [RCW-1:0] rx_count_q, rx_count_d;
    logic           rx_overrun_q, rx_overrun_d;

    logic tx_empty;
    logic tx_push;
    logic tx_pop;
    logic rx_full;
    logic rx_byte_present;
    logic rx_push;
    logic rx_pop;
    logic ovr_set;

    assign tx_empty = (tx_count_q == '0);
    assign tx_full  = (tx_count_q == TCW'(TX_DEPTH));
    assign tx_count = tx_count_q;

    assign uart_dat_we = !tx_empty && !rst;
    assign uart_dat_di = tx_mem_q[tx_rptr_q];

    // Full is judged on registered state, so a pop this cycle never frees a slot for a push.
    assign tx_push = tx_we && !tx_full;
    assign tx_pop  = uart_dat_we && !uart_dat_wait;

    assign rx_full  = (rx_count_q == RCW'(RX_DEPTH));
    assign rx_valid = (rx_count_q != '0);
    assign rx_count = rx_count_q;
    assign rx_do    = rx_mem_q[rx_rptr_q];

    assign rx_byte_present = (uart_dat_do != 32'hFFFF_FFFF);
    assign uart_dat_re     = rx_byte_present && !rst;

    assign rx_pop  = rx_re && rx_valid;
    assign rx_push = rx_byte_present && (!rx_full || rx_re) && !rx_flush;
    assign ovr_set = rx_byte_present && rx_full && !rx_re && !rx_flush;

    always_comb begin
        tx_wptr_d  = tx_wptr_q;
        tx_rptr_d  = tx_rptr_q;
        tx_count_d = tx_count_q;
        if (tx_push) begin
            tx_wptr_d = tx_wptr_q + TAW'(1);
        end
        if (tx_pop) begin
            tx_rptr_d = tx_rptr_q + TAW'(1);
        end
        case ({tx_push, tx_pop})
            2'b10:   tx_count_d = tx_count_q + TCW'(1);
            2'b01:   tx_count_d = tx_count_q - TCW'(1);
            default: tx_count_d = tx_count_q;
        endcase
        if (tx_flush) begin
            tx_wptr_d  = '0;
            tx_rptr_d  = '0;
            tx_count_d = '0;
        end
    end

    always_comb begin
        rx_wptr_d    = rx_wptr_q;
        rx_rptr_d    = rx_rptr_q;
        rx_count_d   = rx_count_q;
        rx_overrun_d = rx_overrun_q;
        if (rx_push) begin
            rx_wptr_d = rx_wptr_q + RAW'(1);
        end
        if (rx_pop) begin
            rx_rptr_d = rx_rptr_q + RAW'(1);
        end
        case ({rx_push, rx_pop})
            2'b10:   rx_count_d = rx_count_q + RCW'(1);
            2'b01:   rx_count_d = rx_count_q - RCW'(1);
            default: rx_count_d = rx_count_q;
        endcase
        if (rx_flush) begin
            rx_wptr_d  = '0;
            rx_rptr_d  = '0;
            rx_count_d = '0;
        end
        if (ovr_set) begin
            rx_overrun_d = 1'b1;
        end else if (clr_overrun) begin
            rx_overrun_d = 1'b0;
        end
    end

    assign rx_overrun = rx_overrun_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wptr_q    <= '0;
            tx_rptr_q    <= '0;
            tx_count_q   <= '0;
            rx_wptr_q    <= '0;
            rx_rptr_q    <= '0;
            rx_count_q   <= '0;
            rx_overrun_q <= 1'b0;
        end else begin
            tx_wptr_q    <= tx_wptr_d;
            tx_rptr_q    <= tx_rptr_d;
            tx_count_q   <= tx_count_d;
            rx_wptr_q    <= rx_wptr_d;
            rx_rptr_q    <= rx_rptr_d;
            rx_count_q   <= rx_count_d;
            rx_overrun_q <= rx_overrun_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && tx_push && !tx_flush) begin
            tx_mem_q[tx_wptr_q] <= tx_di;
        end
        if (!rst && rx_push) begin
            rx_mem_q[rx_wptr_q] <= uart_dat_do[7:0];
        end
    end

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Directed bench for uart_fifo_bridge with 16-entry FIFOs.
// Each task drives one scenario and checks against hand-computed values.
module tb_uart_fifo_bridge;

    logic        clk;
    logic        rst;
    logic        tx_we;
    logic [7:0]  tx_di;
    logic        tx_full;
    logic [4:0]  tx_count;
    logic        tx_flush;
    logic        rx_re;
    logic [7:0]  rx_do;
    logic        rx_valid;
    logic [4:0]  rx_count;
    logic        rx_flush;
    logic        rx_overrun;
    logic        clr_overrun;
    logic        uart_dat_we;
    logic [7:0]  uart_dat_di;
    logic        uart_dat_wait;
    logic        uart_dat_re;
    logic [31:0] uart_dat_do;

    int n_cmp = 0;
    int n_err = 0;

    uart_fifo_bridge #(.TX_DEPTH(16), .RX_DEPTH(16)) dut (
        .clk(clk), .rst(rst),
        .tx_we(tx_we), .tx_di(tx_di), .tx_full(tx_full),
        .tx_count(tx_count), .tx_flush(tx_flush),
        .rx_re(rx_re), .rx_do(rx_do), .rx_valid(rx_valid),
        .rx_count(rx_count), .rx_flush(rx_flush),
        .rx_overrun(rx_overrun), .clr_overrun(clr_overrun),
        .uart_dat_we(uart_dat_we), .uart_dat_di(uart_dat_di),
        .uart_dat_wait(uart_dat_wait), .uart_dat_re(uart_dat_re),
        .uart_dat_do(uart_dat_do)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_cmp++;
        if (uart_dat_we !== 1'b0 || uart_dat_re !== 1'b0) begin
            n_err++;
            $display("FAIL reset_uart_we_re: got %b%b want 00", uart_dat_we, uart_dat_re);
        end
        rst = 1'b0;
        step();
        n_cmp++;
        if (tx_full !== 1'b0 || tx_count !== 5'd0) begin
            n_err++;
            $display("FAIL reset_tx: got full=%b cnt=%0d want 0/0", tx_full, tx_count);
        end
        n_cmp++;
        if (rx_valid !== 1'b0 || rx_count !== 5'd0 || rx_overrun !== 1'b0) begin
            n_err++;
            $display("FAIL reset_rx: got v=%b cnt=%0d ovr=%b want 0/0/0", rx_valid, rx_count, rx_overrun);
        end
    endtask

    task automatic test_tx_stream();
        logic [7:0] exp;
        uart_dat_wait = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp = 8'h41 + 8'(i);
            tx_we = 1'b1;
            tx_di = exp;
            step();
            n_cmp++;
            if (uart_dat_we !== 1'b1 || uart_dat_di !== exp) begin
                n_err++;
                $display("FAIL tx_stream_%0d: got we=%b di=%h want 1/%h", i, uart_dat_we, uart_dat_di, exp);
            end
        end
        tx_we = 1'b0;
        step();
        n_cmp++;
        if (tx_count !== 5'd0 || uart_dat_we !== 1'b0) begin
            n_err++;
            $display("FAIL tx_stream_drained: got cnt=%0d we=%b want 0/0", tx_count, uart_dat_we);
        end
    endtask

    task automatic test_tx_wait();
        int bad = 0;
        uart_dat_wait = 1'b1;
        tx_we = 1'b1;
        tx_di = 8'h55;
        step();
        tx_we = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (uart_dat_we !== 1'b1 || uart_dat_di !== 8'h55) bad++;
            step();
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL tx_wait_hold: got %0d bad cycles want 0", bad);
        end
        n_cmp++;
        if (tx_count !== 5'd1) begin
            n_err++;
            $display("FAIL tx_wait_count: got %0d want 1", tx_count);
        end
        uart_dat_wait = 1'b0;
        step();
        n_cmp++;
        if (tx_count !== 5'd0 || uart_dat_we !== 1'b0) begin
            n_err++;
            $display("FAIL tx_wait_pop: got cnt=%0d we=%b want 0/0", tx_count, uart_dat_we);
        end
    endtask

    task automatic test_tx_full();
        int bad = 0;
        uart_dat_wait = 1'b1;
        for (int i = 0; i < 17; i++) begin
            tx_we = 1'b1;
            tx_di = 8'(i);
            step();
        end
        tx_we = 1'b0;
        n_cmp++;
        if (tx_full !== 1'b1 || tx_count !== 5'd16) begin
            n_err++;
            $display("FAIL tx_full: got full=%b cnt=%0d want 1/16", tx_full, tx_count);
        end
        uart_dat_wait = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (uart_dat_we !== 1'b1 || uart_dat_di !== 8'(i)) begin
                bad++;
                $display("FAIL tx_full_order_%0d: got we=%b di=%h want 1/%h", i, uart_dat_we, uart_dat_di, 8'(i));
            end
            step();
        end
        n_cmp++;
        if (bad != 0) n_err++;
        n_cmp++;
        if (tx_count !== 5'd0 || uart_dat_we !== 1'b0) begin
            n_err++;
            $display("FAIL tx_full_drained: got cnt=%0d we=%b want 0/0", tx_count, uart_dat_we);
        end
    endtask

    task automatic test_tx_flush();
        uart_dat_wait = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tx_we = 1'b1;
            tx_di = 8'hA0 + 8'(i);
            step();
        end
        tx_we = 1'b0;
        tx_flush = 1'b1;
        step();
        tx_flush = 1'b0;
        n_cmp++;
        if (tx_count !== 5'd0 || uart_dat_we !== 1'b0) begin
            n_err++;
            $display("FAIL tx_flush: got cnt=%0d we=%b want 0/0", tx_count, uart_dat_we);
        end
        uart_dat_wait = 1'b0;
    endtask

    task automatic test_rx_capture();
        uart_dat_do = 32'h0000_005A;
        #1;
        n_cmp++;
        if (uart_dat_re !== 1'b1) begin
            n_err++;
            $display("FAIL rx_re_pulse: got %b want 1", uart_dat_re);
        end
        step();
        uart_dat_do = 32'hFFFF_FFFF;
        #1;
        n_cmp++;
        if (rx_valid !== 1'b1 || rx_do !== 8'h5A || rx_count !== 5'd1) begin
            n_err++;
            $display("FAIL rx_capture: got v=%b do=%h cnt=%0d want 1/5a/1", rx_valid, rx_do, rx_count);
        end
        n_cmp++;
        if (uart_dat_re !== 1'b0) begin
            n_err++;
            $display("FAIL rx_re_idle: got %b want 0", uart_dat_re);
        end
        rx_re = 1'b1;
        step();
        rx_re = 1'b0;
        n_cmp++;
        if (rx_valid !== 1'b0 || rx_count !== 5'd0) begin
            n_err++;
            $display("FAIL rx_pop: got v=%b cnt=%0d want 0/0", rx_valid, rx_count);
        end
    endtask

    task automatic test_rx_overrun();
        logic [7:0] exp;
        int bad = 0;
        for (int i = 0; i < 16; i++) begin
            uart_dat_do = 32'h80 + 32'(i);
            step();
        end
        uart_dat_do = 32'h0000_0077;
        step();
        uart_dat_do = 32'hFFFF_FFFF;
        n_cmp++;
        if (rx_overrun !== 1'b1 || rx_count !== 5'd16 || rx_do !== 8'h80) begin
            n_err++;
            $display("FAIL rx_overrun_set: got ovr=%b cnt=%0d do=%h want 1/16/80", rx_overrun, rx_count, rx_do);
        end
        clr_overrun = 1'b1;
        step();
        clr_overrun = 1'b0;
        n_cmp++;
        if (rx_overrun !== 1'b0) begin
            n_err++;
            $display("FAIL rx_overrun_clr: got %b want 0", rx_overrun);
        end
        uart_dat_do = 32'h0000_0077;
        rx_re = 1'b1;
        step();
        rx_re = 1'b0;
        uart_dat_do = 32'hFFFF_FFFF;
        n_cmp++;
        if (rx_overrun !== 1'b0 || rx_count !== 5'd16 || rx_do !== 8'h81) begin
            n_err++;
            $display("FAIL rx_full_swap: got ovr=%b cnt=%0d do=%h want 0/16/81", rx_overrun, rx_count, rx_do);
        end
        for (int i = 0; i < 16; i++) begin
            exp = (i < 15) ? 8'h81 + 8'(i) : 8'h77;
            if (rx_valid !== 1'b1 || rx_do !== exp) begin
                bad++;
                $display("FAIL rx_drain_%0d: got v=%b do=%h want 1/%h", i, rx_valid, rx_do, exp);
            end
            rx_re = 1'b1;
            step();
        end
        rx_re = 1'b0;
        n_cmp++;
        if (bad != 0) n_err++;
        n_cmp++;
        if (rx_count !== 5'd0 || rx_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rx_drained: got cnt=%0d v=%b want 0/0", rx_count, rx_valid);
        end
    endtask

    task automatic test_rx_flush();
        for (int i = 0; i < 2; i++) begin
            uart_dat_do = 32'h10 + 32'(i);
            step();
        end
        uart_dat_do = 32'h0000_0099;
        rx_flush = 1'b1;
        step();
        rx_flush = 1'b0;
        uart_dat_do = 32'hFFFF_FFFF;
        n_cmp++;
        if (rx_count !== 5'd0 || rx_valid !== 1'b0 || rx_overrun !== 1'b0) begin
            n_err++;
            $display("FAIL rx_flush: got cnt=%0d v=%b ovr=%b want 0/0/0", rx_count, rx_valid, rx_overrun);
        end
    endtask

    task automatic test_reset_mid();
        uart_dat_wait = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tx_we = 1'b1;
            tx_di = 8'hC0 + 8'(i);
            step();
        end
        tx_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            uart_dat_do = 32'h20 + 32'(i);
            step();
        end
        n_cmp++;
        if (tx_count !== 5'd5 || rx_count !== 5'd3) begin
            n_err++;
            $display("FAIL mid_prefill: got tx=%0d rx=%0d want 5/3", tx_count, rx_count);
        end
        uart_dat_wait = 1'b0;
        uart_dat_do = 32'h0000_0033;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (uart_dat_we !== 1'b0 || uart_dat_re !== 1'b0) begin
            n_err++;
            $display("FAIL mid_rst_gate: got we=%b re=%b want 0/0", uart_dat_we, uart_dat_re);
        end
        step();
        rst = 1'b0;
        uart_dat_do = 32'hFFFF_FFFF;
        #1;
        n_cmp++;
        if (tx_count !== 5'd0 || rx_count !== 5'd0 || rx_valid !== 1'b0 || uart_dat_we !== 1'b0) begin
            n_err++;
            $display("FAIL mid_rst_after: got tx=%0d rx=%0d v=%b we=%b want 0/0/0/0", tx_count, rx_count, rx_valid, uart_dat_we);
        end
    endtask

    initial begin
        rst = 1'b1;
        tx_we = 1'b0;
        tx_di = 8'h00;
        tx_flush = 1'b0;
        rx_re = 1'b0;
        rx_flush = 1'b0;
        clr_overrun = 1'b0;
        uart_dat_wait = 1'b0;
        uart_dat_do = 32'hFFFF_FFFF;
        test_reset();
        test_tx_stream();
        test_tx_wait();
        test_tx_full();
        test_tx_flush();
        test_rx_capture();
        test_rx_overrun();
        test_rx_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
